// File: rtl/bram_responder_pkg.sv
// Shared definitions for the block-RAM bus responder: bus width, the
// default memory map, FSM state encoding and elaboration helpers.
package bram_responder_pkg;

  localparam int          BUS_W             = 32;
  localparam logic [31:0] INVALID_ADDR      = 32'hffff_ffff;
  localparam logic [31:0] BRAM_BASE_DEFAULT = 32'hf000_0000;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  // True when n is a positive power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port RAM: synchronous write, registered read, block-RAM inferable.
module bram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem [DEPTH];

  // Write or read one word per enabled cycle; dout holds between reads.
  // NOTE: the array has no reset so it maps onto block RAM and its contents survive rst.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_responder.sv
// Bus responder in front of a block RAM: decodes the address window,
// waits a fixed number of cycles, then returns one response cycle.
module bram_responder
  import bram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = BRAM_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] a,
  input  logic [BUS_W-1:0] d,
  input  logic             we,
  input  logic             rd,
  output logic [BUS_W-1:0] spo,
  output logic             ready,
  output logic             err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_END  = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  CNT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam bit          SKIP_BUSY = (WAIT_CYCLES == 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("bram_responder: WAIT_CYCLES must be in 1..15");
  end
  if (!is_pow2(DEPTH_WORDS)) begin : g_bad_depth
    $error("bram_responder: DEPTH_WORDS must be a power of two");
  end

  state_t           state;
  logic [3:0]       cnt;
  logic             resp_q;
  logic             wr_q;
  logic             oor_q;
  logic [BUS_W-1:0] d_q;
  logic [BUS_W-1:0] spo_q;
  logic [BUS_W-1:0] ram_dout;
  logic [BUS_W-1:0] resp_data;
  logic [AW-1:0]    ram_addr;
  logic             req;
  logic             accept;
  logic             in_range;
  logic             resp_live;

  // Request decode, window check (33-bit so the top of the map cannot wrap) and response mux.
  assign req       = rd | we;
  assign accept    = (state == ST_IDLE) && req && !rst;
  assign in_range  = ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < ADDR_END);
  assign ram_addr  = a[AW+1:2] - ADDR_BASE[AW+1:2];
  assign resp_live = resp_q && !rst;
  assign resp_data = oor_q ? '0 : (wr_q ? d_q : ram_dout);
  assign spo       = rst ? '0 : (resp_live ? resp_data : spo_q);
  assign err       = resp_live && oor_q;
  assign ready     = (rst || state == ST_IDLE) && !req;

  bram_sp #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW),
    .W     (BUS_W)
  ) u_ram (
    .clk  (clk),
    .en   (accept && in_range),
    .we   (we),
    .addr (ram_addr),
    .din  (d),
    .dout (ram_dout)
  );

  // FSM: accept in IDLE, count down in BUSY, flag the following response cycle.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      resp_q <= 1'b0;
      wr_q   <= 1'b0;
      oor_q  <= 1'b0;
      d_q    <= '0;
      spo_q  <= '0;
    end else begin
      resp_q <= 1'b0;
      if (resp_q) spo_q <= resp_data;
      case (state)
        ST_IDLE: begin
          if (req) begin
            wr_q  <= we;
            oor_q <= !in_range;
            d_q   <= d;
            cnt   <= CNT_LOAD;
            if (SKIP_BUSY) resp_q <= 1'b1;
            else           state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= ST_IDLE;
            resp_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
